// File: rtl/lsu_pkg.sv
// Shared types, widths and lane helpers for the load/store unit.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses
// return an error response instead of being silently aligned down).
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;

  // Access widths in bits
  localparam int unsigned BYTE = 8;
  localparam int unsigned HALF = 16;
  localparam int unsigned WORD = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  // The reserved size encoding behaves as a full word
  function automatic size_t norm_size(input size_t size);
    return (size == SZ_RSVD) ? SZ_WORD : size;
  endfunction

  // Byte lanes touched by an access of the given size at a lane offset
  function automatic logic [LANES-1:0] lane_mask(input size_t size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Lane offset with the misaligning low bits cleared
  function automatic logic [1:0] align_off(input size_t size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  // True when the low address bits do not match the access size
  function automatic logic is_misaligned(input size_t size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension, and
// merge of byte/half store data into the previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  size_t             size,
  input  logic              is_unsigned,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] merged_c
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] wd_shift;
  logic [DATA_W-1:0] byte_mask;
  logic [LANES-1:0]  lanes;
  logic              sign_b;
  logic              sign_h;

  assign shamt    = {offset, 3'b000};
  assign rd_shift = rd_word >> shamt;
  assign wd_shift = wdata << shamt;
  assign lanes    = lane_mask(size, offset);
  assign sign_b   = ~is_unsigned & rd_shift[BYTE-1];
  assign sign_h   = ~is_unsigned & rd_shift[HALF-1];

  // Expand the per-lane mask to a per-bit mask
  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      byte_mask[i*8 +: 8] = {8{lanes[i]}};
    end
  end

  // Load result: selected lane(s) right-justified and extended
  always_comb begin
    load_data_c = rd_shift;
    case (size)
      SZ_BYTE: load_data_c = {{(DATA_W-BYTE){sign_b}}, rd_shift[BYTE-1:0]};
      SZ_HALF: load_data_c = {{(DATA_W-HALF){sign_h}}, rd_shift[HALF-1:0]};
      default: load_data_c = rd_word;
    endcase
  end

  // Store word: new lanes from wdata, untouched lanes from the old word
  assign merged_c = (rd_word & ~byte_mask) | (wd_shift & byte_mask);

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts byte-addressed load/store requests and drives a
// word-addressed memory port (combinational read, negedge write).
// Sub-word stores are done as read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INDEX = 5
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic             req_we_in,
  input  size_t            req_size_in,
  input  logic             req_unsigned_in,
  input  logic [WIDTH-1:0] req_addr_in,
  input  logic [WIDTH-1:0] req_wdata_in,
  output logic             rsp_valid_out,
  input  logic             rsp_ready_in,
  output logic [WIDTH-1:0] rsp_rdata_out,
  output logic             rsp_err_out,
  output logic             mem_we_out,
  output logic             mem_re_out,
  output logic [INDEX-1:0] mem_addr_out,
  output logic [WIDTH-1:0] mem_data_out,
  input  logic [WIDTH-1:0] mem_data_in
);

  state_t           state;
  logic             op_we;
  logic             op_unsigned;
  size_t            op_size;
  logic [1:0]       op_off;
  logic [WIDTH-1:0] op_wdata;

  size_t            req_size_c;
  logic [1:0]       req_off_c;
  logic             trap_c;
  logic [WIDTH-1:0] load_data_c;
  logic [WIDTH-1:0] merged_c;
  logic             unused_addr;

  assign req_size_c = norm_size(req_size_in);
  assign req_off_c  = align_off(req_size_c, req_addr_in[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_c = is_misaligned(req_size_c, req_addr_in[1:0]);
`else
  assign trap_c = 1'b0;
`endif

  // Address bits above the word index do not select anything
  assign unused_addr = ^req_addr_in[WIDTH-1:INDEX+2];

  lsu_align u_align (
    .size        (op_size),
    .is_unsigned (op_unsigned),
    .offset      (op_off),
    .rd_word     (mem_data_in),
    .wdata       (op_wdata),
    .load_data_c (load_data_c),
    .merged_c    (merged_c)
  );

  // Control FSM with registered request, response and memory-port outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= S_IDLE;
      req_ready_out <= 1'b1;
      rsp_valid_out <= 1'b0;
      rsp_rdata_out <= '0;
      rsp_err_out   <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_re_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_data_out  <= '0;
      op_we         <= 1'b0;
      op_unsigned   <= 1'b0;
      op_size       <= SZ_BYTE;
      op_off        <= 2'b00;
      op_wdata      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_in) begin
            req_ready_out <= 1'b0;
            op_we         <= req_we_in;
            op_unsigned   <= req_unsigned_in;
            op_size       <= req_size_c;
            op_off        <= req_off_c;
            op_wdata      <= req_wdata_in;
            mem_addr_out  <= req_addr_in[INDEX+1:2];
            rsp_err_out   <= 1'b0;
            if (trap_c) begin
              state         <= S_RESP;
              rsp_valid_out <= 1'b1;
              rsp_err_out   <= 1'b1;
              rsp_rdata_out <= '0;
            end else if (req_we_in && (req_size_c == SZ_WORD)) begin
              state        <= S_WRITE;
              mem_we_out   <= 1'b1;
              mem_data_out <= req_wdata_in;
            end else begin
              state      <= S_READ;
              mem_re_out <= 1'b1;
            end
          end
        end
        S_READ: begin
          mem_re_out <= 1'b0;
          if (op_we) begin
            state        <= S_WRITE;
            mem_we_out   <= 1'b1;
            mem_data_out <= merged_c;
          end else begin
            state         <= S_RESP;
            rsp_valid_out <= 1'b1;
            rsp_rdata_out <= load_data_c;
          end
        end
        S_WRITE: begin
          state         <= S_RESP;
          mem_we_out    <= 1'b0;
          rsp_valid_out <= 1'b1;
          rsp_rdata_out <= '0;
        end
        S_RESP: begin
          if (rsp_ready_in) begin
            state         <= S_IDLE;
            rsp_valid_out <= 1'b0;
            req_ready_out <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed scenarios followed by random requests, checked
// against a byte-level reference memory model.
module tb_lsu;
  import lsu_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned INDEX = 5;
  localparam int unsigned DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  size_t            req_size;
  logic             req_unsigned;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic             mem_we;
  logic             mem_re;
  logic [INDEX-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  logic [31:0] mem      [DEPTH];
  logic [31:0] init_mem [DEPTH];
  logic [31:0] ref_mem  [DEPTH];
  logic        load_req;
  int          re_cnt = 0;
  int          we_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  lsu #(.WIDTH(WIDTH), .INDEX(INDEX)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .req_valid_in    (req_valid),
    .req_ready_out   (req_ready),
    .req_we_in       (req_we),
    .req_size_in     (req_size),
    .req_unsigned_in (req_unsigned),
    .req_addr_in     (req_addr),
    .req_wdata_in    (req_wdata),
    .rsp_valid_out   (rsp_valid),
    .rsp_ready_in    (rsp_ready),
    .rsp_rdata_out   (rsp_rdata),
    .rsp_err_out     (rsp_err),
    .mem_we_out      (mem_we),
    .mem_re_out      (mem_re),
    .mem_addr_out    (mem_addr),
    .mem_data_out    (mem_wdata),
    .mem_data_in     (mem_rdata)
  );

  // Data memory: combinational read, write on the falling edge
  assign mem_rdata = mem[mem_addr];
  always @(negedge clk) begin
    if (load_req) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_mem[i];
    end else if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Count memory strobe cycles
  always @(negedge clk) begin
    if (mem_re === 1'b1) re_cnt <= re_cnt + 1;
    if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (byte-addressed memory) ----------------
  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[(a / 4) % DEPTH];
    return w[8*(a % 4) +: 8];
  endfunction

  task automatic put_byte(input logic [31:0] a, input logic [7:0] b);
    ref_mem[(a / 4) % DEPTH][8*(a % 4) +: 8] = b;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] ea, input int unsigned n, input logic uns);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < int'(n); i++) v = v | (32'(get_byte(ea + 32'(i))) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold,
                        output logic [31:0] got);
    logic [31:0] ea, exp_rd;
    logic        exp_err, trap;
    int          exp_lat, exp_re, exp_we, lat, n, re0, we0;
    int unsigned nb;
    nb = nbytes(sz);
    ea = addr & ~(32'(nb) - 32'd1);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (addr % nb) != 0;
`else
    trap = 1'b0;
`endif
    if (trap) begin
      exp_rd = 0; exp_err = 1'b1; exp_lat = 1; exp_re = 0; exp_we = 0;
    end else if (we) begin
      for (int i = 0; i < int'(nb); i++) put_byte(ea + 32'(i), wd[8*i +: 8]);
      exp_rd = 0; exp_err = 1'b0; exp_we = 1;
      exp_re  = (nb == 4) ? 0 : 1;
      exp_lat = (nb == 4) ? 2 : 3;
    end else begin
      exp_rd = model_load(ea, nb, uns); exp_err = 1'b0;
      exp_lat = 2; exp_re = 1; exp_we = 0;
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size_t'(sz);
    req_unsigned = uns; req_addr = addr; req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    re0 = re_cnt; we0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    got = rsp_rdata;

    // Stall the response; a competing request must not be taken
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (h == 0) begin
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD;
        req_addr = $urandom; req_wdata = $urandom;
      end
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    check("re_pulses", 32'(re_cnt - re0), 32'(exp_re));
    check("we_pulses", 32'(we_cnt - we0), 32'(exp_we));
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_BYTE;
    req_unsigned = 1'b0; req_addr = 0; req_wdata = 0; rsp_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) init_mem[i] = $urandom;
    init_mem[1] = 32'h8899AABB;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_mem[i];
    load_req = 1'b1;
    repeat (3) @(negedge clk);
    load_req = 1'b0;

    // Reset values
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Signed and unsigned byte loads from the top lane
    do_req(1'b0, 2'd0, 1'b0, 32'h7, 32'h0, 0, got);
    check("lb_signed", got, 32'hFFFFFF88);
    do_req(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, 0, got);
    check("lbu", got, 32'h00000088);

    // Misaligned word load
    do_req(1'b0, 2'd2, 1'b0, 32'h5, 32'h0, 0, got);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_misaligned", got, 32'h0);
`else
    check("lw_misaligned", got, 32'h8899AABB);
`endif

    // Word load with a stalled response
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 3, got);
    check("lw_stall", got, 32'h8899AABB);

    // Half store via read-modify-write
    do_req(1'b1, 2'd1, 1'b0, 32'h6, 32'h00001234, 0, got);
    check("sh_word1", mem[1], 32'h1234AABB);

    // Word store
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 0, got);
    check("sw_rdata", got, 32'h0);
    check("sw_word2", mem[2], 32'hDEADBEEF);

    // Reset while the write strobe is up, before its falling edge
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE;
    req_unsigned = 1'b0; req_addr = 32'h4; req_wdata = 32'h11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rmw_we_up", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_mem_we", 32'(mem_we), 32'd0);
    check("rstmid_mem_re", 32'(mem_re), 32'd0);
    check("rstmid_req_ready", 32'(req_ready), 32'd1);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_mem_addr", 32'(mem_addr), 32'd0);
    check("rstmid_mem_data", mem_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_word1", mem[1], 32'h1234AABB);
    rst_n = 1'b1;

    // Random traffic against the reference model
    for (int t = 0; t < 200; t++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 3));
      do_req(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom_range(0, 2), got);
    end

    @(negedge clk);
    for (int i = 0; i < int'(DEPTH); i++) check("final_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
